// File: rtl/load_use_scoreboard_pkg.sv
// Shared types and constants for the load-use hazard scoreboard.
// Register address width, register count, stage tag layout and pending-counter width.
package load_use_scoreboard_pkg;

  localparam int REG_ADDR_W = 2;
  localparam int NUM_REGS   = 4;
  localparam int PEND_CNT_W = 2;

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic                  memread;
    logic [REG_ADDR_W-1:0] rd;
  } stage_tag_t;

  function automatic logic src_hits(input logic                  use_src,
                                    input logic [REG_ADDR_W-1:0] src,
                                    input logic [REG_ADDR_W-1:0] rd);
    return use_src && (src == rd);
  endfunction

endpackage

// File: rtl/scoreboard_counter.sv
// Per-register count of in-flight writers; issue and retire in the same cycle cancel.
module scoreboard_counter
  import load_use_scoreboard_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  inc,
  input  logic                  dec,
  output logic [PEND_CNT_W-1:0] count,
  output logic                  nonzero
);

  logic [PEND_CNT_W-1:0] count_q;
  logic [PEND_CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    case ({inc, dec})
      2'b10:   count_d = count_q + PEND_CNT_W'(1);
      2'b01:   count_d = count_q - PEND_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count   = count_q;
  assign nonzero = |count_q;

  // Wrapping in either direction means the pipeline lost track of a writer.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(inc && !dec && (count_q == '1)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(dec && !inc && (count_q == '0)));

endmodule

// File: rtl/load_use_scoreboard.sv
// Tracks EX/MEM/WB destination tags, raises a one-cycle stall on a load-use hazard
// and keeps per-register pending-writer counts plus a saturating stall statistic.
module load_use_scoreboard
  import load_use_scoreboard_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic                   id_use_rs,
  input  logic                   id_use_rt,
  input  logic                   id_regwrite,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic                   id_memread,
  input  logic                   flush,
  input  logic                   stat_clr,
  output logic                   stall,
  output logic [NUM_REGS-1:0]    pending_mask,
  output logic                   busy,
  output logic [STALL_CNT_W-1:0] stall_count
);

  stage_tag_t ex_q, mem_q, wb_q, ex_d;
  logic       issue;

  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d;

  logic [PEND_CNT_W-1:0]          pend_cnt [NUM_REGS];
  logic [NUM_REGS*PEND_CNT_W-1:0] unused_pend_cnt;
  logic                           unused_wb_memread;

  // Only a load sitting in EX needs a bubble; one cycle later it is in MEM and forwardable.
  always_comb begin
    stall = id_valid && !flush && ex_q.valid && ex_q.regwrite && ex_q.memread &&
            (src_hits(id_use_rs, id_rs, ex_q.rd) || src_hits(id_use_rt, id_rt, ex_q.rd));
  end

  assign issue = id_valid && !stall && !flush;

  always_comb begin
    ex_d = '0;
    if (issue) begin
      ex_d.valid    = 1'b1;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      ex_d.rd       = id_rd;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    logic inc, dec;
    assign inc = issue && id_regwrite && (id_rd == REG_ADDR_W'(r));
    assign dec = wb_q.valid && wb_q.regwrite && (wb_q.rd == REG_ADDR_W'(r));

    scoreboard_counter u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (inc),
      .dec     (dec),
      .count   (pend_cnt[r]),
      .nonzero (pending_mask[r])
    );

    assign unused_pend_cnt[r*PEND_CNT_W +: PEND_CNT_W] = pend_cnt[r];
  end

  assign unused_wb_memread = wb_q.memread;

  assign busy = (ex_q.valid  && ex_q.regwrite) ||
                (mem_q.valid && mem_q.regwrite) ||
                (wb_q.valid  && wb_q.regwrite);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stat_clr)
      stall_cnt_d = '0;
    else if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Directed bench for load_use_scoreboard with a 4-bit stall counter.
module tb_load_use_scoreboard;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, flush, stat_clr;
  logic [1:0] id_rs, id_rt, id_rd;
  logic       stall, busy;
  logic [3:0] pending_mask;
  logic [3:0] stall_count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_sc = 0;

  always #5 clk = ~clk;

  load_use_scoreboard #(.STALL_CNT_W(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_regwrite  (id_regwrite),
    .id_rd        (id_rd),
    .id_memread   (id_memread),
    .flush        (flush),
    .stat_clr     (stat_clr),
    .stall        (stall),
    .pending_mask (pending_mask),
    .busy         (busy),
    .stall_count  (stall_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] rs, input logic urs,
                       input logic [1:0] rt, input logic urt, input logic rw,
                       input logic [1:0] rd, input logic mr, input logic fl);
    id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    id_regwrite = rw; id_rd = rd; id_memread = mr; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n  = 1'b0;
    stat_clr = 1'b0;
    idle();
    #1;
    check("rst_async_stall", 32'(stall), 32'd0);
    check("rst_async_mask", 32'(pending_mask), 32'h0);
    step(); step();
    reset_n = 1'b1;
    repeat (5) step();
    @(negedge clk);
    check("idle_stall", 32'(stall), 32'd0);
    check("idle_mask", 32'(pending_mask), 32'h0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_sc", 32'(stall_count), 32'd0);

    // Load r1, then a reader of r1 that itself writes r0.
    step();
    drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
    @(negedge clk);
    check("lu_no_stall_on_load", 32'(stall), 32'd0);
    step();
    drive(1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_mask_load", 32'(pending_mask), 32'h2);
    check("lu_busy", 32'(busy), 32'd1);
    step();
    exp_sc = 1;
    @(negedge clk);
    check("lu_stall_one_cycle", 32'(stall), 32'd0);
    check("lu_sc", 32'(stall_count), 32'(exp_sc));
    check("lu_reader_held", 32'(pending_mask), 32'h2);
    step();
    idle();
    @(negedge clk);
    check("lu_reader_in_ex", 32'(pending_mask), 32'h3);
    step(); step(); step();
    @(negedge clk);
    check("lu_drain_mask", 32'(pending_mask), 32'h0);
    check("lu_drain_busy", 32'(busy), 32'd0);

    // ALU write to r2, then a reader of r2: no stall.
    step();
    drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    step();
    drive(1'b1, 2'd2, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("alu_no_stall", 32'(stall), 32'd0);
    check("alu_mask_c1", 32'(pending_mask), 32'h4);
    step();
    idle();
    @(negedge clk);
    check("alu_mask_c2", 32'(pending_mask), 32'h4);
    step();
    @(negedge clk);
    check("alu_mask_c3", 32'(pending_mask), 32'h4);
    step();
    @(negedge clk);
    check("alu_mask_clear", 32'(pending_mask), 32'h0);

    // Load r3, then a flushed reader of r3 (which would write r0).
    step();
    drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0);
    step();
    drive(1'b1, 2'd3, 1'b1, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
    @(negedge clk);
    check("flush_no_stall", 32'(stall), 32'd0);
    step();
    idle();
    @(negedge clk);
    check("flush_bubble", 32'(pending_mask), 32'h8);
    check("flush_sc", 32'(stall_count), 32'(exp_sc));
    step(); step();
    @(negedge clk);
    check("flush_drain", 32'(pending_mask), 32'h0);

    // Four back-to-back writes to r0.
    step();
    drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    step(); step(); step();
    @(negedge clk);
    check("wr0_cnt3", 32'(dut.pend_cnt[0]), 32'd3);
    check("wr0_mask", 32'(pending_mask), 32'h1);
    step();
    idle();
    @(negedge clk);
    check("wr0_cnt_hold", 32'(dut.pend_cnt[0]), 32'd3);
    step(); step();
    @(negedge clk);
    check("wr0_mask_late", 32'(pending_mask), 32'h1);
    step();
    @(negedge clk);
    check("wr0_mask_clear", 32'(pending_mask), 32'h0);
    check("wr0_busy_clear", 32'(busy), 32'd0);

    // 17 load-use stalls on the rt path; the 4-bit counter saturates at 15.
    for (int i = 0; i < 17; i++) begin
      step();
      drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
      step();
      drive(1'b1, 2'd0, 1'b0, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      check("sat_stall", 32'(stall), 32'd1);
      step();
      exp_sc = (exp_sc == 15) ? 15 : exp_sc + 1;
      @(negedge clk);
      check("sat_sc", 32'(stall_count), 32'(exp_sc));
      check("sat_one_cycle", 32'(stall), 32'd0);
    end
    step();
    idle();
    @(negedge clk);
    check("sat_final", 32'(stall_count), 32'd15);
    repeat (4) step();

    // stat_clr during a stall cycle.
    drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
    step();
    drive(1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    stat_clr = 1'b1;
    @(negedge clk);
    check("clr_stall", 32'(stall), 32'd1);
    step();
    stat_clr = 1'b0;
    exp_sc = 0;
    @(negedge clk);
    check("clr_sc", 32'(stall_count), 32'(exp_sc));
    step();
    idle();
    repeat (4) step();

    // Asynchronous reset mid-operation with r1 and r2 pending and a stall raised.
    drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    step();
    drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
    step();
    drive(1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("mid_mask", 32'(pending_mask), 32'h6);
    check("mid_stall", 32'(stall), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_mask", 32'(pending_mask), 32'h0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    idle();
    step(); step();
    reset_n = 1'b1;
    repeat (4) step();
    @(negedge clk);
    check("post_rst_mask", 32'(pending_mask), 32'h0);
    check("post_rst_sc", 32'(stall_count), 32'd0);
    step();
    drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
    step();
    idle();
    @(negedge clk);
    check("post_rst_issue_mask", 32'(pending_mask), 32'h8);
    check("post_rst_issue_busy", 32'(busy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_use_scoreboard.md
LOAD_USE_SCOREBOARD -- requirements
Module: load_use_scoreboard

Interface
REQ-001 Parameter STALL_CNT_W, default 16, SHALL set the width of the stall statistics counter.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 id_valid  in  1  SHALL mark a valid instruction in ID.
REQ-005 id_rs, id_rt  in  2 each  SHALL be the ID source register addresses.
REQ-006 id_use_rs, id_use_rt  in  1 each  SHALL mark that the corresponding source is actually read.
REQ-007 id_regwrite  in  1  SHALL mark that the ID instruction writes a register.
REQ-008 id_rd  in  2  SHALL be the ID destination register address.
REQ-009 id_memread  in  1  SHALL mark the ID instruction as a load.
REQ-010 flush  in  1  SHALL squash the ID instruction, e.g. on branch redirect.
REQ-011 stat_clr  in  1  SHALL synchronously clear stall_count.
REQ-012 stall  out  1  SHALL hold PC and IF/ID and request a bubble into EX.
REQ-013 pending_mask  out  4  SHALL have bit r set while register r has an in-flight writer.
REQ-014 busy  out  1  SHALL be high while any in-flight tag has regwrite set.
REQ-015 stall_count  out  STALL_CNT_W  SHALL count stall cycles, saturating.

Function
REQ-016 The block SHALL hold three tag stages EX, MEM and WB; each tag is {valid, regwrite, memread, rd}.
REQ-017 On each clock edge: EX->MEM, MEM->WB, WB retires.
REQ-018 On each clock edge, EX SHALL load the ID fields if id_valid & !stall & !flush; otherwise EX SHALL load an invalid bubble.
REQ-019 stall SHALL be combinational: id_valid & !flush & EX.valid & EX.regwrite & EX.memread & ((id_use_rs & EX.rd==id_rs) | (id_use_rt & EX.rd==id_rt)).
REQ-020 A load-use hazard SHALL produce exactly one stall cycle, because the bubble moves the load to MEM, where forwarding covers it.
REQ-021 flush SHALL take priority over stall: stall=0 while flush=1.
REQ-022 Each register r SHALL have a 2-bit pending counter.
REQ-023 The pending counter SHALL update as +1 when an issue targets r with regwrite, and -1 when the retiring WB tag is valid & regwrite with rd==r.
REQ-024 Simultaneous issue and retire to the same r SHALL leave its counter unchanged.
REQ-025 A pending counter SHALL never exceed 3 or go below 0; violation is an assertion failure.
REQ-026 pending_mask[r] SHALL equal (counter[r]!=0), derived from registered state only.
REQ-027 An ID-stage reader of a register with pending_mask set but no load in EX SHALL NOT stall.
REQ-028 stall_count SHALL increment by 1 on each clock edge where stall=1, and hold at all-ones.
REQ-029 stat_clr SHALL win over a simultaneous increment, leaving stall_count at 0.

Reset
REQ-030 While reset_n=0, all tags SHALL be invalid, all counters 0, stall_count 0, and therefore stall=0, pending_mask=0000 and busy=0, without waiting for a clock.
REQ-031 A reset asserted mid-operation SHALL discard all in-flight tags, with no retire decrements applied afterward.
REQ-032 After reset_n rises, the first clock edge SHALL behave as a normal edge.

Structure
REQ-033 A shared package SHALL hold: REG_ADDR_W=2; NUM_REGS=4; the stage-tag typedef; and the pending-counter width constant.
REQ-034 The per-register counter SHALL be one sub-module, scoreboard_counter, instantiated NUM_REGS times.
REQ-035 scoreboard_counter inputs SHALL be inc and dec; its outputs SHALL be count and nonzero.

Verification
REQ-036 Reset then idle 5 cycles -> stall=0, pending_mask=0000, busy=0, stall_count=0.
REQ-037 Load rd=1, then next cycle a reader with id_rs=1, id_use_rs=1 -> stall=1 for exactly one cycle, stall_count=1, and the reader enters EX one cycle later.
REQ-038 ALU write rd=2 (memread=0), then a reader of r2 -> stall=0; pending_mask=0100 for 3 cycles, then 0000.
REQ-039 Load rd=3, then a reader of r3 with flush=1 in the same cycle -> stall=0, EX gets a bubble, stall_count unchanged.
REQ-040 Three back-to-back writes to r0 -> counter[0] reaches 3; on the 4th write the issue and retire coincide, so the counter stays 3; mask bit0 clears 3 cycles after the last issue.
REQ-041 With STALL_CNT_W=4, 17 load-use stalls -> stall_count=15; then stat_clr with stall=1 -> 0; then reset_n low with pending_mask=0110 -> 0000 immediately.
